// File: rtl/rca_64bit_pkg.sv
// Shared definitions for the ripple-carry adder slice.
// Contents: default operand width and a matching word type.
package rca_pkg;

  localparam int unsigned RCA_DEFAULT_WIDTH = 64;

  typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_word_t;

endpackage : rca_pkg

// File: rtl/rca_64bit_if.sv
// Operand/result bundle for rca_64bit.
// Signals:
//   a, b : addends (WIDTH bits)
//   c0   : carry-in into bit 0
//   s    : registered sum (WIDTH bits)
//   c    : registered carry-out
//   ov   : registered signed overflow (only when RCA_OVERFLOW_EN is defined)
// Modports: master drives operands and reads results; slave is the adder side.
import rca_pkg::*;

interface rca_64bit_if #(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c0;
  logic [WIDTH-1:0] s;
  logic             c;
`ifdef RCA_OVERFLOW_EN
  logic             ov;
`endif

`ifdef RCA_OVERFLOW_EN
  modport master (output a, output b, output c0, input s, input c, input ov);
  modport slave  (input a, input b, input c0, output s, output c, output ov);
`else
  modport master (output a, output b, output c0, input s, input c);
  modport slave  (input a, input b, input c0, output s, output c);
`endif

endinterface : rca_64bit_if

// File: rtl/rca_64bit_fa.sv
// Single-bit full adder, purely combinational.
// Ports:
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : fa_1bit

// File: rtl/rca_64bit.sv
// Ripple-carry adder with registered result: {c, s} = a + b + c0, one cycle latency,
// one operation per cycle, no handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears s/c (and ov)
//   bus : rca_64bit_if.slave carrying a, b, c0 in and s, c (ov) out
// Build option: define RCA_OVERFLOW_EN to add the registered signed-overflow flag ov.
import rca_pkg::*;

module rca_64bit #(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  rca_64bit_if.slave   bus
);

  // carry[i] enters bit i; carry[WIDTH] is the final carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = bus.c0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_1bit u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.s  <= '0;
      bus.c  <= 1'b0;
`ifdef RCA_OVERFLOW_EN
      bus.ov <= 1'b0;
`endif
    end else begin
      bus.s  <= sum;
      bus.c  <= carry[WIDTH];
`ifdef RCA_OVERFLOW_EN
      // Signed overflow: carry into the sign bit differs from carry out of it.
      bus.ov <= carry[WIDTH] ^ carry[WIDTH-1];
`endif
    end
  end

endmodule : rca_64bit

// File: tb/tb_rca_64bit.sv
import rca_pkg::*;

module tb_rca_64bit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rca_64bit_if #(.WIDTH(64)) bus ();

  rca_64bit #(.WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    rca_word_t a;
    rca_word_t b;
    logic      c0;
    rca_word_t exp_s;
    logic      exp_c;
    logic      exp_ov;
  } vec_t;

  typedef struct {
    rca_word_t s;
    logic      c;
    logic      ov;
  } res_t;

  // Reference: plain wide arithmetic plus sign-rule overflow.
  function automatic res_t model(rca_word_t a, rca_word_t b, logic c0);
    logic [64:0] full;
    res_t r;
    full = {1'b0, a} + {1'b0, b} + {64'd0, c0};
    r.s  = full[63:0];
    r.c  = full[64];
    r.ov = (a[63] == b[63]) && (r.s[63] != a[63]);
    return r;
  endfunction

  task automatic check(string name, res_t exp);
    n_tests++;
    if (bus.s !== exp.s || bus.c !== exp.c) begin
      n_fail++;
      $display("FAIL %s: got s=%h c=%b, expected s=%h c=%b", name, bus.s, bus.c, exp.s, exp.c);
    end
`ifdef RCA_OVERFLOW_EN
    n_tests++;
    if (bus.ov !== exp.ov) begin
      n_fail++;
      $display("FAIL %s_ov: got ov=%b, expected ov=%b", name, bus.ov, exp.ov);
    end
`endif
  endtask

  task automatic drive(rca_word_t a, rca_word_t b, logic c0);
    bus.a  = a;
    bus.b  = b;
    bus.c0 = c0;
  endtask

  vec_t vecs[6];
  res_t exp_q[$];
  res_t e;

  initial begin
    vecs[0] = '{64'h02EB02EB02EB02EB, 64'h555502EB02EB02EB, 1'b0, 64'h584005D605D605D6, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0,                1'b1, 64'h0,                1'b1, 1'b0};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{64'h7FFFFFFFFFFFFFFF, 64'h1,                1'b0, 64'h8000000000000000, 1'b0, 1'b1};
    vecs[4] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0,                1'b1, 1'b1};
    vecs[5] = '{64'h0,                64'h0,                1'b1, 64'h1,                1'b0, 1'b0};

    // Reset state, with nonzero operands present.
    drive(64'h1234, 64'h5678, 1'b1);
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    #1;
    e = '{64'h0, 1'b0, 1'b0};
    check("reset", e);

    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].c0);
      @(posedge clk);
      #1;
      e = '{vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_ov};
      check($sformatf("vec%0d", i), e);
      @(negedge clk);
    end

    // Back-to-back random stream: each result one edge after its operands.
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      rca_word_t ra, rb;
      logic rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: ra = '1;
        1: rb = ~ra;
        2: ra = {1'b0, ra[62:0]};
        default: ;
      endcase
      drive(ra, rb, rc);
      exp_q.push_back(model(ra, rb, rc));
      @(negedge clk);
      check($sformatf("stream%0d", i), exp_q.pop_front());
    end

    // Reset mid-stream with nonzero operands, then release.
    drive(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b1);
    @(negedge clk);
    check("pre_rst", model(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b1));
    rst = 1'b1;
    @(negedge clk);
    e = '{64'h0, 1'b0, 1'b0};
    check("mid_rst", e);
    rst = 1'b0;
    drive(64'hFFFFFFFF00000000, 64'h00000001FFFFFFFF, 1'b1);
    @(negedge clk);
    check("post_rst", model(64'hFFFFFFFF00000000, 64'h00000001FFFFFFFF, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rca_64bit
